// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the ram_arbiter slice: FSM state encoding,
// requester index type and a modulo helper used by the picker and the pointer.
package ram_arbiter_pkg;

  localparam int ARB_MAX_REQ  = 8;
  localparam int ARB_IDX_BITS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } t_arb_state;

  typedef logic [ARB_IDX_BITS-1:0] t_arb_idx;

  function automatic t_arb_idx wrap_idx(input int value, input int modulus);
    return t_arb_idx'(value % modulus);
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side bus of ram_arbiter. The arbiter uses the slave
// modport; requesters plus the RAM (or a bench) sit on the master side.
interface ram_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_BITS = 8,
  parameter int WORD_BITS = 8
);

  logic [NUM_REQ-1:0]                in_req;
  logic [NUM_REQ-1:0]                in_write;
  logic [NUM_REQ-1:0][ADDR_BITS-1:0] in_addr;
  logic [NUM_REQ-1:0][WORD_BITS-1:0] in_data;
  logic [NUM_REQ-1:0]                out_ack;
  logic [WORD_BITS-1:0]              out_data;
  logic                              out_busy;
  logic                              out_ram_read_ena;
  logic                              out_ram_write_ena;
  logic [ADDR_BITS-1:0]              out_ram_addr;
  logic [WORD_BITS-1:0]              out_ram_data;
  logic [WORD_BITS-1:0]              in_ram_data;

  modport master (
    output in_req, in_write, in_addr, in_data, in_ram_data,
    input  out_ack, out_data, out_busy, out_ram_read_ena, out_ram_write_ena,
           out_ram_addr, out_ram_data
  );

  modport slave (
    input  in_req, in_write, in_addr, in_data, in_ram_data,
    output out_ack, out_data, out_busy, out_ram_read_ena, out_ram_write_ena,
           out_ram_addr, out_ram_data
  );

endinterface

// File: rtl/ram_arbiter_pick.sv
// Combinational winner picker: first set request at or after ptr, with wrap.
// With RAM_ARBITER_ROUND_ROBIN_EN undefined the top ties ptr to 0 (fixed priority).
module ram_arbiter_pick
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  t_arb_idx           ptr,
  output t_arb_idx           winner,
  output logic               valid
);

  logic [NUM_REQ-1:0] rot_s;
  t_arb_idx           off_s;

  // rotate so ptr lands on bit 0, encode lowest set bit, add ptr back
  always_comb begin
    rot_s = '0;
    off_s = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        rot_s[i] = (wrap_idx(int'(ptr) + i, NUM_REQ) == t_arb_idx'(j)) ? req[j] : rot_s[i];
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? t_arb_idx'(i) : off_s;
      valid = valid | rot_s[i];
    end
    winner = wrap_idx(int'(ptr) + int'(off_s), NUM_REQ);
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates NUM_REQ requesters onto one synchronous RAM port (IDLE/ISSUE/DONE).
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin picking; otherwise fixed priority.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_BITS = 8,
  parameter int WORD_BITS = 8
) (
  input logic           in_clk,
  input logic           in_rst,
  ram_arbiter_if.slave  bus
);

  t_arb_state           state_r;
  t_arb_idx             winner_r;
  logic                 write_r;
  logic [NUM_REQ-1:0]   ack_r;
  logic                 busy_r;
  logic                 rd_en_r;
  logic                 wr_en_r;
  logic [ADDR_BITS-1:0] ram_addr_r;
  logic [WORD_BITS-1:0] ram_data_r;

  t_arb_idx             ptr_s;
  t_arb_idx             pick_idx_s;
  logic                 pick_valid_s;
  logic                 sel_write_s;
  logic [ADDR_BITS-1:0] sel_addr_s;
  logic [WORD_BITS-1:0] sel_data_s;
  logic [NUM_REQ-1:0]   ack_next_s;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  t_arb_idx ptr_r;

  // pointer moves past the winner as its ack is issued
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      ptr_r <= '0;
    end else if (state_r == DONE) begin
      ptr_r <= wrap_idx(int'(winner_r) + 1, NUM_REQ);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr_s = ptr_r;
`else
  assign ptr_s = '0;
`endif

  ram_arbiter_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.in_req),
    .ptr    (ptr_s),
    .winner (pick_idx_s),
    .valid  (pick_valid_s)
  );

  // select the picked requester's fields and decode the latched winner
  always_comb begin
    sel_write_s = 1'b0;
    sel_addr_s  = '0;
    sel_data_s  = '0;
    ack_next_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_write_s   = (pick_idx_s == t_arb_idx'(i)) ? bus.in_write[i] : sel_write_s;
      sel_addr_s    = (pick_idx_s == t_arb_idx'(i)) ? bus.in_addr[i]  : sel_addr_s;
      sel_data_s    = (pick_idx_s == t_arb_idx'(i)) ? bus.in_data[i]  : sel_data_s;
      ack_next_s[i] = (winner_r == t_arb_idx'(i));
    end
  end

  // transaction FSM; the RAM port registers double as the committed request
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_r    <= IDLE;
      winner_r   <= '0;
      write_r    <= 1'b0;
      ack_r      <= '0;
      busy_r     <= 1'b0;
      rd_en_r    <= 1'b0;
      wr_en_r    <= 1'b0;
      ram_addr_r <= '0;
      ram_data_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r <= '0;
          if (pick_valid_s) begin
            state_r    <= ISSUE;
            winner_r   <= pick_idx_s;
            write_r    <= sel_write_s;
            busy_r     <= 1'b1;
            rd_en_r    <= ~sel_write_s;
            wr_en_r    <= sel_write_s;
            ram_addr_r <= sel_addr_s;
            ram_data_r <= sel_data_s;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            rd_en_r <= 1'b0;
            wr_en_r <= 1'b0;
          end
        end
        ISSUE: begin
          state_r <= DONE;
          rd_en_r <= 1'b0;
          wr_en_r <= 1'b0;
          ack_r   <= ack_next_s;
          busy_r  <= 1'b1;
        end
        DONE: begin
          state_r <= IDLE;
          ack_r   <= '0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          ack_r   <= '0;
          busy_r  <= 1'b0;
          rd_en_r <= 1'b0;
          wr_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_ack           = ack_r;
  assign bus.out_busy          = busy_r;
  assign bus.out_ram_read_ena  = rd_en_r;
  assign bus.out_ram_write_ena = wr_en_r;
  assign bus.out_ram_addr      = ram_addr_r;
  assign bus.out_ram_data      = ram_data_r;
  // RAM read data is only valid in DONE, so it is gated rather than re-registered
  assign bus.out_data          = ((|ack_r) & ~write_r) ? bus.in_ram_data : '0;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares one port of the `ram` block between `NUM_REQ` requesters, such as a CPU fetch unit, a DMA engine and a debug interface. Each access is a request/acknowledge transaction. The block picks one winner per transaction, drives the RAM port for exactly one cycle, and returns the read data with a registered acknowledge. It sits between the requesters and the `ram` port and contains no storage beyond the latched winning request.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..8).
- `ADDR_BITS`, 8: RAM address width.
- `WORD_BITS`, 8: RAM word width.

Ports:
- `in_clk` in 1: system clock. Only clock; all logic is rising-edge.
- `in_rst` in 1: reset, synchronous, active-high.
- `in_req` in `[NUM_REQ]`: per-requester access request, level.
- `in_write` in `[NUM_REQ]`: 1 = write, 0 = read; valid while `in_req`.
- `in_addr` in `[NUM_REQ][ADDR_BITS]`: per-requester address.
- `in_data` in `[NUM_REQ][WORD_BITS]`: per-requester write data.
- `out_ack` in→out `[NUM_REQ]`: one-cycle completion pulse, one-hot or zero.
- `out_data` out `WORD_BITS`: read data; valid while any `out_ack` bit is set.
- `out_busy` out 1: high while a transaction is in flight (any state other than IDLE).
- `out_ram_read_ena` out 1: to `ram` `in_read_ena`.
- `out_ram_write_ena` out 1: to `ram` `in_write_ena`.
- `out_ram_addr` out `ADDR_BITS`: to `ram` `in_addr`.
- `out_ram_data` out `WORD_BITS`: to `ram` `in_data`.
- `in_ram_data` in `WORD_BITS`: from `ram` `out_data`. The RAM has a 1-cycle synchronous read.

## Operation
- FSM states are IDLE, ISSUE and DONE. It leaves IDLE only when `in_req` is nonzero.
- **IDLE → ISSUE**:
  - The winner index is latched from the picker.
  - The winner's write flag, address and data are latched.
  - The request is committed at this point. Later changes or dropping of that requester's `in_req`, `in_addr`, `in_data` or `in_write` do not affect the transaction.
- **ISSUE → DONE**:
  - `out_ram_*` are driven from the latched request.
  - Exactly one of `out_ram_read_ena` or `out_ram_write_ena` is high.
- **DONE → IDLE**:
  - `out_ack[winner]` is 1.
  - For reads, `out_data` = `in_ram_data`. For writes, `out_data` = 0.
  - The round-robin pointer is updated to winner+1, modulo `NUM_REQ`.
- **Requester rule**: deassert `in_req` on the same edge that samples `out_ack`. If `in_req` is still high in the next IDLE cycle, it is treated as a new request.
- **Picking**: the first set `in_req` bit at or after the pointer, searching with wrap-around. An index at or above `NUM_REQ` never wins.
- Outside ISSUE, `out_ram_read_ena` and `out_ram_write_ena` are 0. `out_ram_addr` and `out_ram_data` hold their last value.

## Timing
- **Reset**:
  - Synchronous reset forces, on that edge:
    - the state to IDLE;
    - the pointer to 0;
    - `out_ack`, `out_busy` and both RAM enables to 0;
    - `out_ram_addr`, `out_ram_data` and `out_data` to 0.
  - A reset in ISSUE or DONE aborts the transaction with no ack.
  - A write already presented in ISSUE may have completed in the RAM.
- **Latency**: an ack arrives 3 cycles after the `in_req` sampling edge: 1 cycle IDLE, 1 ISSUE, 1 DONE.
- **Throughput**: one access per 3 cycles.
- **Busy**: `out_busy` is registered. It is high in ISSUE and DONE.
- **Simultaneous requests**: exactly one winner per IDLE cycle. The others wait with `in_req` held.
- **Fairness**: with all requesters continuously active, each is served once every `NUM_REQ` transactions.

## Configuration
- **`RAM_ARBITER_ROUND_ROBIN_EN` defined**: rotating-pointer round-robin picking, as described above.
- **`RAM_ARBITER_ROUND_ROBIN_EN` undefined**:
  - Fixed priority: the lowest set index always wins.
  - The pointer register is not built.
  - All other behaviour and timing are identical.

## Structure
- **Package `ram_arbiter_pkg`**: the FSM state enum `t_arb_state` (IDLE, ISSUE, DONE) and the constant `ARB_MAX_REQ = 8`.
- **Sub-module `ram_arbiter_pick`**: combinational. Inputs are the request vector and the pointer. Outputs are the winner index and a valid flag.
  - Round-robin is a rotate, then a priority-encode, then an add-back of the pointer.
  - Under fixed priority the pointer is tied to 0.

## Test plan
- **Reset**: hold `in_rst`=1 for 2 cycles → all outputs 0, `out_busy`=0, state IDLE.
- **Write then read**:
  - Req0 writes 0xAB at 0x12 → `out_ram_write_ena`=1 with addr 0x12 and data 0xAB in cycle 2; `out_ack`=01 in cycle 3.
  - Req0 then reads 0x12 → `out_data`=0xAB with `out_ack`=01.
- **Contention**: req0 and req1 both read from cycle 0 (0x12 and 0xFF; 0xFF never written) → req0 acked first; req1 acked 3 cycles later with `out_data`=0x00 (fresh RAM).
- **Fairness** (round-robin build): both requests held through 4 transactions → ack order 0,1,0,1. Under fixed priority with req0 always re-requesting → order 0,0,0,0.
- **Commit**: req1 drops `in_req` and changes `in_addr` the cycle after the latch → the transaction completes on the latched address and `out_ack`=10 is still issued.
- **Reset mid-op**: `in_rst` pulsed during ISSUE → no ack, enables 0 next cycle, pointer 0, next request served normally.
